// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter with parity, 1/2 stop bits and a one-word holding register.
// Optional line-break generation is compiled in with `define UART_TX_BREAK_EN.
module uart_tx_frame #(
  parameter int CLOCK_FREQ = 1_843_200,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data_in,
`ifdef UART_TX_BREAK_EN
  input  logic                 brk,
`endif
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic                 tx
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int CW = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam int BW = 4;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY == 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx_frame: CLOCK_FREQ/BAUD_RATE must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
`ifdef UART_TX_BREAK_EN
    , S_BREAK, S_BRKSTOP
`endif
  } state_t;

  state_t               state_q;
  logic [CW-1:0]        baud_q;
  logic [BW-1:0]        bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] hold_q;
  logic                 par_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 tx_q;

  logic                 bit_end;
  logic                 frame_end;
  logic                 idle_go;
  logic                 load;
  logic                 accept;
  logic [DATA_BITS-1:0] load_word;

  assign bit_end   = (baud_q == BAUD_LAST);
  assign frame_end = (state_q == S_STOP) && bit_end && (bit_q == STOP_LAST);
  assign accept    = start && ready_q;
`ifdef UART_TX_BREAK_EN
  assign idle_go   = (state_q == S_IDLE) && start && !brk;
`else
  assign idle_go   = (state_q == S_IDLE) && start;
`endif
  // A full holding register wins at frame end; otherwise a same-edge start goes straight in.
  assign load      = idle_go || (frame_end && (!ready_q || start));
  assign load_word = (frame_end && !ready_q) ? hold_q : data_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      hold_q  <= '0;
      par_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      done_q <= 1'b0;
      baud_q <= bit_end ? '0 : baud_q + CW'(1);
      case (state_q)
        S_IDLE: begin
          baud_q <= '0;
          bit_q  <= '0;
`ifdef UART_TX_BREAK_EN
          if (brk) begin
            state_q <= S_BREAK;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end
`endif
        end
        S_START: begin
          if (bit_end) begin
            state_q <= S_DATA;
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
            bit_q   <= '0;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_q == DATA_LAST) begin
              bit_q <= '0;
              if (PARITY != 0) begin
                state_q <= S_PARITY;
                tx_q    <= par_q;
              end else begin
                state_q <= S_STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_q   <= bit_q + BW'(1);
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            state_q <= S_STOP;
            tx_q    <= 1'b1;
            bit_q   <= '0;
          end
        end
        S_STOP: begin
          if (frame_end) begin
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            if (ready_q && !start) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else if (bit_end) begin
            bit_q <= bit_q + BW'(1);
          end
        end
`ifdef UART_TX_BREAK_EN
        S_BREAK: begin
          baud_q <= '0;
          bit_q  <= '0;
          if (!brk) begin
            state_q <= S_BRKSTOP;
            tx_q    <= 1'b1;
          end
        end
        S_BRKSTOP: begin
          if (bit_end) begin
            if (bit_q == STOP_LAST) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
            end else begin
              bit_q <= bit_q + BW'(1);
            end
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase

      if (load) begin
        state_q <= S_START;
        tx_q    <= 1'b0;
        busy_q  <= 1'b1;
        shift_q <= load_word;
        par_q   <= (^load_word) ^ ODD;
        baud_q  <= '0;
        bit_q   <= '0;
      end

      if (accept && (state_q != S_IDLE) && !frame_end) begin
        hold_q  <= data_in;
        ready_q <= 1'b0;
      end
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign tx    = tx_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: expected line bits are queued at stimulus time and
// popped as the serial line is sampled every cycle on the falling edge.
module tb_uart_tx_frame;

  localparam int C = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [8:0] din = '0;
  logic       brk = 1'b0;
  int         sel = 0;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  logic       st0, st1, st2, st3;
  logic [3:0] tx_v, busy_v, ready_v, done_v;
  logic       tx_o, busy_o, ready_o, done_o;
  logic       exp_q[$];

  assign st0 = start && (sel == 0);
  assign st1 = start && (sel == 1);
  assign st2 = start && (sel == 2);
  assign st3 = start && (sel == 3);

  uart_tx_frame u_d8 (
    .clk(clk), .rst(rst), .start(st0), .data_in(din[7:0]),
`ifdef UART_TX_BREAK_EN
    .brk(brk),
`endif
    .ready(ready_v[0]), .busy(busy_v[0]), .done(done_v[0]), .tx(tx_v[0]));

  uart_tx_frame #(.PARITY(2), .STOP_BITS(2)) u_p2 (
    .clk(clk), .rst(rst), .start(st1), .data_in(din[7:0]),
`ifdef UART_TX_BREAK_EN
    .brk(1'b0),
`endif
    .ready(ready_v[1]), .busy(busy_v[1]), .done(done_v[1]), .tx(tx_v[1]));

  uart_tx_frame #(.PARITY(1), .STOP_BITS(2)) u_p1 (
    .clk(clk), .rst(rst), .start(st2), .data_in(din[7:0]),
`ifdef UART_TX_BREAK_EN
    .brk(1'b0),
`endif
    .ready(ready_v[2]), .busy(busy_v[2]), .done(done_v[2]), .tx(tx_v[2]));

  uart_tx_frame #(.DATA_BITS(5)) u_d5 (
    .clk(clk), .rst(rst), .start(st3), .data_in(din[4:0]),
`ifdef UART_TX_BREAK_EN
    .brk(1'b0),
`endif
    .ready(ready_v[3]), .busy(busy_v[3]), .done(done_v[3]), .tx(tx_v[3]));

  always_comb begin
    tx_o    = tx_v[sel[1:0]];
    busy_o  = busy_v[sel[1:0]];
    ready_o = ready_v[sel[1:0]];
    done_o  = done_v[sel[1:0]];
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_at(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Frame bits derived from the line format: start, data LSB first, parity, stops.
  task automatic push_frame(input logic [8:0] d, input int nb, input int par, input int stops);
    int ones;
    ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      exp_q.push_back(d[i]);
      if (d[i]) ones++;
    end
    if (par == 1) exp_q.push_back((ones % 2) == 0);
    if (par == 2) exp_q.push_back((ones % 2) == 1);
    for (int i = 0; i < stops; i++) exp_q.push_back(1'b1);
  endtask

  task automatic send(input logic [8:0] d, output int acc);
    start = 1'b1;
    din   = d;
    acc   = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Samples every cycle from the accepting edge to one cycle past the last frame.
  task automatic watch(input string tag, input int acc, input int nfr, input int f,
                       input int inj_j, input logic [8:0] inj_d, input int ign_j,
                       input int rlo, input int rhi);
    logic cur;
    cur = 1'b1;
    for (int j = 0; j <= nfr * f; j++) begin
      wait_at(acc + j);
      if (j < nfr * f) begin
        if ((j % C) == 0) begin
          if (exp_q.size() > 0) cur = exp_q.pop_front();
          else cur = 1'b1;
        end
      end else begin
        cur = 1'b1;
      end
      chk({tag, ".tx"}, 9'(tx_o), 9'(cur));
      chk({tag, ".done"}, 9'(done_o), 9'(j > 0 && (j % f) == 0));
      chk({tag, ".busy"}, 9'(busy_o), 9'(j < nfr * f));
      chk({tag, ".ready"}, 9'(ready_o), 9'(!(j >= rlo && j < rhi)));
      if (j == inj_j - 1 || j == ign_j) begin
        start = 1'b1;
        din   = (j == ign_j) ? 9'h0FF : inj_d;
      end
      if (j == inj_j || j == ign_j + 1) start = 1'b0;
    end
  endtask

  initial begin
    int acc;
    #1 rst = 1'b1;
    #1;
    chk("reset.tx", 9'(tx_o), 9'd1);
    chk("reset.busy", 9'(busy_o), 9'd0);
    chk("reset.ready", 9'(ready_o), 9'd1);
    chk("reset.done", 9'(done_o), 9'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    sel = 0;
    push_frame(9'h055, 8, 0, 1);
    send(9'h055, acc);
    watch("8n1_55", acc, 1, 160, -10, '0, -10, -1, -1);

    push_frame(9'h0A5, 8, 0, 1);
    push_frame(9'h03C, 8, 0, 1);
    send(9'h0A5, acc);
    watch("b2b", acc, 2, 160, 40, 9'h03C, 80, 40, 160);

    sel = 1;
    @(negedge clk);
    push_frame(9'h055, 8, 2, 2);
    send(9'h055, acc);
    watch("p2s2", acc, 1, 192, -10, '0, -10, -1, -1);

    sel = 2;
    @(negedge clk);
    push_frame(9'h055, 8, 1, 2);
    send(9'h055, acc);
    watch("p1s2", acc, 1, 192, -10, '0, -10, -1, -1);

    sel = 3;
    @(negedge clk);
    push_frame(9'h013, 5, 0, 1);
    send(9'h013, acc);
    watch("d5", acc, 1, 112, -10, '0, -10, -1, -1);

    sel = 0;
    @(negedge clk);
    send(9'h05A, acc);
    wait_at(acc + 20);
    start = 1'b1;
    din   = 9'h0C3;
    wait_at(acc + 21);
    start = 1'b0;
    chk("rstmid.ready_pre", 9'(ready_o), 9'd0);
    wait_at(acc + 50);
    chk("rstmid.tx_pre", 9'(tx_o), 9'd0);
    #2 rst = 1'b1;
    #1;
    chk("rstmid.tx", 9'(tx_o), 9'd1);
    chk("rstmid.busy", 9'(busy_o), 9'd0);
    chk("rstmid.ready", 9'(ready_o), 9'd1);
    chk("rstmid.done", 9'(done_o), 9'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      chk("rstmid.quiet_tx", 9'(tx_o), 9'd1);
      chk("rstmid.quiet_done", 9'(done_o), 9'd0);
    end
    exp_q.delete();
    push_frame(9'h00F, 8, 0, 1);
    send(9'h00F, acc);
    watch("after_rst", acc, 1, 160, -10, '0, -10, -1, -1);

`ifdef UART_TX_BREAK_EN
    brk = 1'b1;
    acc = cyc + 1;
    for (int j = 0; j <= 116; j++) begin
      wait_at(acc + j);
      chk("brk.tx", 9'(tx_o), 9'(j >= 100));
      chk("brk.busy", 9'(busy_o), 9'(j < 116));
      chk("brk.done", 9'(done_o), 9'd0);
      if (j < 100) chk("brk.ready", 9'(ready_o), 9'd0);
      if (j == 99) brk = 1'b0;
    end
    chk("brk.ready_end", 9'(ready_o), 9'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
